// File: rtl/pwm_pkg.sv
// Shared PWM definitions: meter FSM states and default widths.
// Used by pwm_duty_meter and pwm_in_sync (filter macro PWM_METER_FILTER_EN).
package pwm_pkg;

    localparam int PWM_CNT_W   = 16;
    localparam int PWM_TIMEOUT = 50000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_STUCK
    } meter_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// PWM input conditioning: 2-flop sync, optional debounce, edge detect.
// Debounce enabled by defining PWM_METER_FILTER_EN (FILT_LEN samples).
module pwm_in_sync
    import pwm_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk_main,
    input  logic rst_n,
    input  logic pwm_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_lvl_d;
    logic w_lvl;

    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end

    // Two-flop synchronizer for the asynchronous PWM line
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_METER_FILTER_EN
    localparam int HW = (FILT_LEN > 1) ? FILT_LEN - 1 : 1;

    logic [HW-1:0] r_hist;

    // History of previous synchronized samples for the debounce window
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else begin
            r_hist <= (r_hist << 1) | HW'(r_sync2);
        end
    end

    // Accept the new level only when the whole window agrees
    assign w_lvl = (r_hist == {HW{r_sync2}}) ? r_sync2 : r_lvl_d;
`else
    assign w_lvl = r_sync2;
`endif

    // Previous accepted level, the reference for edge detection
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_d <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;
        end
    end

    assign lvl  = w_lvl;
    assign rise = w_lvl & ~r_lvl_d;
    assign fall = ~w_lvl & r_lvl_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM period / high-time meter with stuck-line detection.
// Optional input debounce via PWM_METER_FILTER_EN (see pwm_in_sync).
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W    = PWM_CNT_W,
    parameter int TIMEOUT  = PWM_TIMEOUT,
    parameter int FILT_LEN = 3
) (
    input  logic             clk_main,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if (TIMEOUT < 2 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_tmo
        $error("TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_W");
    end

    logic             w_lvl;
    logic             w_rise;
    logic             w_fall;
    logic             w_tmo;
    logic             w_publish;
    meter_state_t     r_state;
    meter_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] w_per_nxt;
    logic [CNT_W-1:0] w_hi_nxt;
    logic [CNT_W-1:0] w_per_inc;
    logic [CNT_W-1:0] w_hi_inc;

    pwm_in_sync #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .clk_main (clk_main),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .lvl      (w_lvl),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    // Counters saturate at TIMEOUT so they can never wrap
    assign w_tmo     = (r_per_cnt >= TMO);
    assign w_per_inc = w_tmo ? TMO : r_per_cnt + ONE;
    assign w_hi_inc  = (r_hi_cnt >= TMO) ? TMO : r_hi_cnt + ONE;

    // Next state, counter updates and publish decision
    always_comb begin
        w_state_nxt = r_state;
        w_per_nxt   = r_per_cnt;
        w_hi_nxt    = r_hi_cnt;
        w_publish   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_per_nxt = '0;
                w_hi_nxt  = '0;
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_per_nxt   = ONE;
                    w_hi_nxt    = ONE;
                end
            end
            ST_HIGH: begin
                if (w_tmo) begin
                    w_state_nxt = ST_STUCK;
                end else if (w_fall) begin
                    w_state_nxt = ST_LOW;
                    w_per_nxt   = w_per_inc;
                end else begin
                    w_per_nxt = w_per_inc;
                    w_hi_nxt  = w_hi_inc;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_publish   = 1'b1;
                    w_per_nxt   = ONE;
                    w_hi_nxt    = ONE;
                end else if (w_tmo) begin
                    w_state_nxt = ST_STUCK;
                end else begin
                    w_per_nxt = w_per_inc;
                end
            end
            ST_STUCK: begin
                w_per_nxt = '0;
                w_hi_nxt  = '0;
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_per_nxt   = ONE;
                    w_hi_nxt    = ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_per_nxt   = '0;
                w_hi_nxt    = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_per_cnt <= w_per_nxt;
            r_hi_cnt  <= w_hi_nxt;
        end
    end

    // Published results hold between strobes; stuck flags follow the FSM
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid  <= 1'b0;
            period_out  <= '0;
            high_out    <= '0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid  <= w_publish;
            stuck       <= (w_state_nxt == ST_STUCK);
            stuck_level <= (w_state_nxt == ST_STUCK) & w_lvl;
            if (w_publish) begin
                period_out <= r_per_cnt;
                high_out   <= r_hi_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter (directed PWM waveforms).
// Glitch expectations depend on PWM_METER_FILTER_EN.
module tb_pwm_duty_meter;

    localparam int CW  = 16;
    localparam int TMO = 2000;

    typedef struct {
        int p;
        int h;
    } exp_t;

    logic          clk_main = 1'b0;
    logic          rst_n;
    logic          pwm_in;
    logic          meas_valid;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic          stuck;
    logic          stuck_level;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t m_e;
    int   prev_p  = 0;
    int   prev_h  = 0;
    bit   prev_ok = 1'b0;

    always #5 clk_main = ~clk_main;

    pwm_duty_meter #(
        .CNT_W    (CW),
        .TIMEOUT  (TMO),
        .FILT_LEN (3)
    ) dut (
        .clk_main    (clk_main),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .meas_valid  (meas_valid),
        .period_out  (period_out),
        .high_out    (high_out),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_main);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(meas_valid), 0);
        chk({tag, "_period"}, int'(period_out), 0);
        chk({tag, "_high"}, int'(high_out), 0);
        chk({tag, "_stuck"}, int'(stuck), 0);
        chk({tag, "_stuck_lvl"}, int'(stuck_level), 0);
    endtask

    // Rising edge: the previous complete period becomes due
    task automatic rise_edge();
        if (prev_ok) q.push_back('{prev_p, prev_h});
        pwm_in = 1'b1;
    endtask

    task automatic period(input int p, input int h);
        rise_edge();
        cyc(h);
        pwm_in = 1'b0;
        cyc(p - h);
        prev_p  = p;
        prev_h  = h;
        prev_ok = 1'b1;
    endtask

    // 100/25 period with a 2-cycle high glitch 40 cycles into the low phase
    task automatic glitch_period();
        rise_edge();
        cyc(25);
        pwm_in = 1'b0;
        cyc(40);
`ifndef PWM_METER_FILTER_EN
        q.push_back('{65, 25});
`endif
        pwm_in = 1'b1;
        cyc(2);
        pwm_in = 1'b0;
        cyc(33);
`ifdef PWM_METER_FILTER_EN
        prev_p = 100;
        prev_h = 25;
`else
        prev_p = 35;
        prev_h = 2;
`endif
        prev_ok = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;

        fork
            forever begin
                @(negedge clk_main);
                if (rst_n && meas_valid) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL strobe: unexpected %0d/%0d, none due",
                                 period_out, high_out);
                    end else begin
                        m_e = q.pop_front();
                        chk("period", int'(period_out), m_e.p);
                        chk("high", int'(high_out), m_e.h);
                    end
                end
            end
        join_none

        cyc(3);
        chk_zero("reset");
        rst_n = 1'b1;
        cyc(5);

        repeat (5) period(100, 25);
        chk("run_stuck", int'(stuck), 0);

        repeat (3) period(40, 30);
        chk("hold_period", int'(period_out), 40);
        chk("hold_high", int'(high_out), 30);
        chk("q_drain1", q.size(), 0);

`ifndef PWM_METER_FILTER_EN
        period(2, 1);
        period(3, 1);
        period(3, 2);
        period(100, 25);
`endif

        glitch_period();
        period(100, 25);
        period(100, 25);
        chk("glitch_hold_p", int'(period_out), 100);
        chk("q_drain2", q.size(), 0);

        rise_edge();
        prev_ok = 1'b0;
        cyc(TMO + 500);
        chk("stuck_hi", int'(stuck), 1);
        chk("stuck_hi_lvl", int'(stuck_level), 1);
        chk("stuck_hi_per", int'(period_out), 100);
        chk("stuck_hi_high", int'(high_out), 25);
        pwm_in = 1'b0;
        cyc(10);
        chk("stuck_track", int'(stuck), 1);
        chk("stuck_track_lvl", int'(stuck_level), 0);

        period(100, 50);
        chk("recover_stuck", int'(stuck), 0);
        chk("recover_per", int'(period_out), 100);
        chk("recover_high", int'(high_out), 25);
        period(100, 50);
        prev_ok = 1'b0;
        chk("recover_pub", int'(high_out), 50);

        cyc(TMO - 300);
        chk("low_early", int'(stuck), 0);
        cyc(300);
        chk("stuck_lo", int'(stuck), 1);
        chk("stuck_lo_lvl", int'(stuck_level), 0);
        chk("stuck_lo_high", int'(high_out), 50);

        period(100, 25);
        rise_edge();
        cyc(10);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        pwm_in  = 1'b0;
        prev_ok = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        repeat (3) period(100, 25);
        rise_edge();
        cyc(10);
        pwm_in = 1'b0;
        cyc(5);
        chk("q_final", q.size(), 0);
        chk("final_high", int'(high_out), 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
